// File: rtl/pc_btb_gen.sv
// ---------------------------------------------------------------------------
// pc_btb_gen -- RV32I IF-stage fetch-address generator with a direct-mapped
// branch target buffer (BTB) and 2-bit saturating direction counters.
//
// The fetch PC is registered. Every cycle the current PC looks up the BTB
// combinationally. The resulting prediction (taken bit plus target) is sent
// to the IF/ID register and, unless something overrides it, becomes the next
// PC. EX can override the fetch stream with a redirect. EX also trains the
// BTB with resolved branches. Each accepted redirect increments a saturating
// counter that is used for performance debug.
//
// Parameters:
//   XLEN          address width in bits
//   BTB_ENTRIES   number of BTB entries (power of two, >= 2)
//   RESET_VECTOR  PC after reset (bits [1:0] must be zero)
//   CNT_WIDTH     width of the mispredict counter
//
// Ports:
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   enable_i           global advance enable (BTB training ignores it)
//   pc_write_i         hazard stall; 0 holds pc (a redirect still wins)
//   redirect_valid_i   EX resolved a mispredict/jump; load redirect_pc_i
//   redirect_pc_i      corrected fetch address (bits [1:0] ignored)
//   upd_valid_i        EX resolved a branch/JAL; train the BTB
//   upd_pc_i           address of the resolved branch
//   upd_target_i       resolved taken target
//   upd_taken_i        resolved direction
//   pc_o               current fetch address (registered)
//   pred_taken_o       BTB predicts taken for pc_o
//   pred_target_o      predicted target, pc_o+4 when not taken
//   mispredict_cnt_o   accepted redirects, saturating at all-ones
// ---------------------------------------------------------------------------
module pc_btb_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     BTB_ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 pc_write_i,
  input  logic                 redirect_valid_i,
  input  logic [XLEN-1:0]      redirect_pc_i,
  input  logic                 upd_valid_i,
  input  logic [XLEN-1:0]      upd_pc_i,
  input  logic [XLEN-1:0]      upd_target_i,
  input  logic                 upd_taken_i,
  output logic [XLEN-1:0]      pc_o,
  output logic                 pred_taken_o,
  output logic [XLEN-1:0]      pred_target_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  localparam logic [XLEN-1:0]      PC_STEP = XLEN'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // 2-bit direction counter states; the MSB is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken (reset state)
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken (fresh allocation)
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0]        pc_q,  pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];

  // -------------------------------------------------------------------------
  // Lookup for the current fetch address
  // -------------------------------------------------------------------------
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic [XLEN-1:0]  lk_target;
  logic [XLEN-1:0]  pc_plus4;

  assign lk_idx   = pc_q[IDX+1:2];
  assign lk_tag   = pc_q[XLEN-1:IDX+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];

  // The sum is truncated to XLEN bits, so the top of the address space wraps
  // to zero.
  assign pc_plus4  = pc_q + PC_STEP;
  assign lk_target = lk_taken ? tgt_q[lk_idx] : pc_plus4;

  // -------------------------------------------------------------------------
  // Next-PC selection and mispredict counter
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb receives a default at the
  // top of the block. Without these defaults, any path that skipped an
  // assignment would infer a latch.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (enable_i) begin
      if (redirect_valid_i) begin
        // A redirect overrides a stall. The younger instructions are being
        // flushed, so there is nothing for the stall to protect.
        pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (pc_write_i) begin
        pc_d = lk_target;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  // This lets every flop sample the pre-edge values of the others, with no
  // dependence on the order in which the blocks are evaluated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // BTB training from EX
  // -------------------------------------------------------------------------
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr_d;

  assign upd_idx = upd_pc_i[IDX+1:2];
  assign upd_tag = upd_pc_i[XLEN-1:IDX+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Saturating step of the trained entry's counter. This value is used only
  // when the update hits.
  always_comb begin
    upd_ctr_d = ctr_q[upd_idx];
    if (upd_taken_i) begin
      if (ctr_q[upd_idx] != CTR_ST) begin
        upd_ctr_d = ctr_q[upd_idx] + 2'b01;
      end
    end else if (ctr_q[upd_idx] != CTR_SNT) begin
      upd_ctr_d = ctr_q[upd_idx] - 2'b01;
    end
  end

  // The valid bits and the counters have defined reset values. Training
  // depends on neither enable_i nor pc_write_i. The lookup above reads the
  // pre-edge contents, so a same-cycle update becomes visible one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_d;
      end else if (upd_taken_i) begin
        // A taken miss allocates the entry and evicts any previous owner.
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_WT;
      end
    end
  end

  // NOTE: the tag and target arrays are deliberately left without a reset.
  // valid_q masks them until they are written, so a reset would only add
  // fan-out to every storage flop without changing behaviour.
  // A taken update writes both fields. When it hits, the tag it rewrites is
  // identical to the stored one. When it misses, the write is the allocation.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i && upd_taken_i) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target_i;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pc_o             = pc_q;
  assign pred_taken_o     = lk_taken;
  assign pred_target_o    = lk_target;
  assign mispredict_cnt_o = cnt_q;

  // Instruction addresses are word aligned, so the byte-offset bits of the
  // incoming addresses carry no information.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{redirect_pc_i[1:0], upd_pc_i[1:0]};

endmodule

// File: tb/tb_pc_btb_gen.sv
// ---------------------------------------------------------------------------
// Testbench for pc_btb_gen.
//
// Two instances are driven with identical stimulus. The first uses the default
// parameters. The second uses CNT_WIDTH=2 to exercise counter saturation.
// Directed scenarios are followed by a randomized phase. The randomized phase
// is checked against an address-level model of the fetch unit and the BTB.
// ---------------------------------------------------------------------------
module tb_pc_btb_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  logic [31:0] pc,  pred_target,  pc2,  pred_target2;
  logic        pred_taken, pred_taken2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  pc_btb_gen u_dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .pc_write_i       (pc_write),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_target_i     (upd_target),
    .upd_taken_i      (upd_taken),
    .pc_o             (pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .mispredict_cnt_o (cnt)
  );

  pc_btb_gen #(.CNT_WIDTH(2)) u_dut2 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .pc_write_i       (pc_write),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_target_i     (upd_target),
    .upd_taken_i      (upd_taken),
    .pc_o             (pc2),
    .pred_taken_o     (pred_taken2),
    .pred_target_o    (pred_target2),
    .mispredict_cnt_o (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (addresses as plain integers) --------
  int unsigned m_pc;
  int          m_cnt;
  bit          m_valid [16];
  int unsigned m_tagv  [16];
  int unsigned m_tgtv  [16];
  int          m_ctr   [16];

  function automatic int unsigned m_idx(input int unsigned a);
    return (a / 4) % 16;
  endfunction

  function automatic int unsigned m_tag(input int unsigned a);
    return a / 64;
  endfunction

  function automatic bit m_pred_taken();
    int unsigned i = m_idx(m_pc);
    return m_valid[i] && (m_tagv[i] == m_tag(m_pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic int unsigned m_pred_target();
    return m_pred_taken() ? m_tgtv[m_idx(m_pc)] : m_pc + 4;
  endfunction

  function automatic int unsigned m_cnt_sat(input int maxv);
    return (m_cnt > maxv) ? maxv : m_cnt;
  endfunction

  task automatic model_reset();
    m_pc  = 0;
    m_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_step();
    int unsigned ptg = m_pred_target();
    int unsigned ui  = m_idx(upd_pc);
    int unsigned ut  = m_tag(upd_pc);
    if (enable) begin
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_cnt++;
      end else if (pc_write) begin
        m_pc = ptg;
      end
    end
    if (upd_valid) begin
      if (m_valid[ui] && m_tagv[ui] == ut) begin
        if (upd_taken) begin
          if (m_ctr[ui] < 3) m_ctr[ui]++;
          m_tgtv[ui] = upd_target;
        end else if (m_ctr[ui] > 0) begin
          m_ctr[ui]--;
        end
      end else if (upd_taken) begin
        m_valid[ui] = 1'b1;
        m_tagv[ui]  = ut;
        m_tgtv[ui]  = upd_target;
        m_ctr[ui]   = 2;
      end
    end
  endtask

  // ---------------- stimulus helpers (no checking) ------------------------
  task automatic set_idle();
    enable         = 1'b1;
    pc_write       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;
  endtask

  // One rising edge. The model advances with the inputs that are stable
  // across that edge, and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Train one entry while holding the fetch PC.
  task automatic train(input logic [31:0] a, input logic [31:0] t, input logic tk);
    pc_write   = 1'b0;
    upd_valid  = 1'b1;
    upd_pc     = a;
    upd_target = t;
    upd_taken  = tk;
    tick();
    upd_valid  = 1'b0;
    pc_write   = 1'b1;
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
    total++; if (pred_target !== 32'h4) begin bad++; $display("FAIL reset_pred_target: got %h want %h", pred_target, 32'h4); end
    total++; if (cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(4 * i)); end
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL seq_pred[%0d]: got %b want 0", i, pred_taken); end
      total++; if (cnt !== 16'h0) begin bad++; $display("FAIL seq_cnt[%0d]: got %0d want 0", i, cnt); end
    end
  endtask

  task automatic test_train();
    // Same-cycle train at the current pc: the lookup still sees a miss.
    upd_valid  = 1'b1;
    upd_pc     = 32'h10;
    upd_target = 32'h40;
    upd_taken  = 1'b1;
    #1;
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL train_same_cycle_pred: got %b want 0", pred_taken); end
    tick();
    upd_valid = 1'b0;
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL train_same_cycle_pc: got %h want %h", pc, 32'h14); end
    redirect_to(32'h10);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL train_pred_taken: got %b want 1", pred_taken); end
    total++; if (pred_target !== 32'h40) begin bad++; $display("FAIL train_pred_target: got %h want %h", pred_target, 32'h40); end
    tick();
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL train_next_pc: got %h want %h", pc, 32'h40); end
  endtask

  task automatic test_hysteresis();
    train(32'h10, 32'h40, 1'b0);          // 10 -> 01
    redirect_to(32'h10);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL hyst_after_nt: got %b want 0", pred_taken); end
    train(32'h10, 32'h40, 1'b1);          // 01 -> 10
    train(32'h10, 32'h40, 1'b1);          // 10 -> 11
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL hyst_after_tt: got %b want 1", pred_taken); end
    train(32'h10, 32'h40, 1'b0);          // 11 -> 10
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL hyst_after_ttn: got %b want 1", pred_taken); end
    total++; if (pred_target !== 32'h40) begin bad++; $display("FAIL hyst_target: got %h want %h", pred_target, 32'h40); end
  endtask

  task automatic test_alias();
    redirect_to(32'h50);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_pred: got %b want 0", pred_taken); end
    total++; if (pred_target !== 32'h54) begin bad++; $display("FAIL alias_target: got %h want %h", pred_target, 32'h54); end
    tick();
    total++; if (pc !== 32'h54) begin bad++; $display("FAIL alias_next_pc: got %h want %h", pc, 32'h54); end
    train(32'h50, 32'h80, 1'b1);
    redirect_to(32'h10);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted: got %b want 0", pred_taken); end
    redirect_to(32'h50);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_new_pred: got %b want 1", pred_taken); end
    total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL alias_new_target: got %h want %h", pred_target, 32'h80); end
  endtask

  task automatic test_redirect_stall();
    int exp_cnt = m_cnt + 1;
    pc_write       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL stall_redirect_pc: got %h want %h", pc, 32'h200); end
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL stall_redirect_cnt: got %0d want %0d", cnt, exp_cnt); end
    enable      = 1'b0;
    redirect_pc = 32'h303;
    tick();
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL disabled_pc: got %h want %h", pc, 32'h200); end
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL disabled_cnt: got %0d want %0d", cnt, exp_cnt); end
    redirect_valid = 1'b0;
    pc_write       = 1'b1;
    tick();
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL disabled_hold: got %h want %h", pc, 32'h200); end
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFF);
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_redirect: got %h want %h", pc, 32'hFFFF_FFFC); end
    total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL wrap_target: got %h want %h", pred_target, 32'h0); end
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
  endtask

  task automatic test_reset_mid_and_saturation();
    redirect_to(32'h50);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL mid_pre_reset_pred: got %b want 1", pred_taken); end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_reset_pred: got %b want 0", pred_taken); end
    total++; if (pred_target !== 32'h4) begin bad++; $display("FAIL mid_reset_target: got %h want %h", pred_target, 32'h4); end
    total++; if (cnt !== 16'h0 || cnt2 !== 2'h0) begin bad++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", cnt, cnt2); end
    #2;
    rst_n = 1'b1;
    tick();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL mid_first_step: got %h want %h", pc, 32'h4); end
    redirect_to(32'h50);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_btb_cleared: got %b want 0", pred_taken); end
    for (int i = 0; i < 4; i++) redirect_to(32'h100);
    total++; if (cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2: got %0d want 3", cnt2); end
    total++; if (cnt !== 16'd5) begin bad++; $display("FAIL sat_cnt16: got %0d want 5", cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable         = ($urandom_range(0, 7) != 0);
      pc_write       = ($urandom_range(0, 5) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom_range(0, 511);
      upd_valid      = ($urandom_range(0, 1) == 1);
      upd_pc         = $urandom_range(0, 31) * 4;
      upd_target     = $urandom_range(0, 127) * 4;
      upd_taken      = ($urandom_range(0, 2) != 0);
      #1;
      total++; if (pred_taken !== m_pred_taken()) begin bad++; $display("FAIL rnd_pred[%0d]: got %b want %b", n, pred_taken, m_pred_taken()); end
      total++; if (pred_target !== m_pred_target()) begin bad++; $display("FAIL rnd_target[%0d]: got %h want %h", n, pred_target, m_pred_target()); end
      tick();
      total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
      total++; if (pc2 !== m_pc) begin bad++; $display("FAIL rnd_pc2[%0d]: got %h want %h", n, pc2, m_pc); end
      total++; if (cnt !== 16'(m_cnt_sat(65535))) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, cnt, m_cnt_sat(65535)); end
      total++; if (cnt2 !== 2'(m_cnt_sat(3))) begin bad++; $display("FAIL rnd_cnt2[%0d]: got %0d want %0d", n, cnt2, m_cnt_sat(3)); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_train();
    test_hysteresis();
    test_alias();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_and_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_btb_gen.md
Name: pc_btb_gen

Overview:
- Parametrised fetch-address generator for the RV32I pipeline IF stage.
- Integrates a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Sources a mispredict/jump redirect from EX and keeps a saturating mispredict counter for performance debug.
- Drives the I-memory address, and passes the prediction bit and target to the IF/ID register.

Parameters:
- XLEN, 32, address/data width in bits.
- BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2. IDX = log2(BTB_ENTRIES).
- RESET_VECTOR, 0, PC value after reset; bits [1:0] must be 0.
- CNT_WIDTH, 16, width of the mispredict performance counter.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  global advance enable; when 0, no architectural state changes except BTB update.
- PCWrite  in  1  hazard-unit stall; 0 holds pc (redirect still wins).
- redirect_valid  in  1  EX resolved a mispredict or jump; load redirect_pc.
- redirect_pc  in  XLEN  corrected fetch address; bits [1:0] are ignored and forced to 0.
- upd_valid  in  1  EX resolved a conditional branch/JAL; update the BTB.
- upd_pc  in  XLEN  address of the resolved branch.
- upd_target  in  XLEN  resolved taken target.
- upd_taken  in  1  resolved direction.
- pc  out  XLEN  current fetch address (registered).
- pred_taken  out  1  BTB predicts taken for the current pc (combinational from pc and BTB state).
- pred_target  out  XLEN  predicted target; equals pc+4 when pred_taken=0.
- mispredict_cnt  out  CNT_WIDTH  count of accepted redirects, saturating.

Behaviour:
- Reset (Reset_n=0, asynchronous): pc=RESET_VECTOR, all BTB valid bits=0, all counters=2'b01, mispredict_cnt=0. pred_taken=0 and pred_target=RESET_VECTOR+4 while in reset.
- Lookup fields: idx=pc[IDX+1:2], tag=pc[XLEN-1:IDX+2].
  - hit = valid[idx] && tag_mem[idx]==tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? tgt[idx] : pc+4.
- Next-pc priority on a rising edge with Enable=1:
  1. redirect_valid=1: pc <= {redirect_pc[XLEN-1:2],2'b00}. Applies even when PCWrite=0. mispredict_cnt increments, holding at all-ones.
  2. PCWrite=0: pc holds.
  3. Otherwise: pc <= pred_target.
- Enable=0: pc and mispredict_cnt hold.
- Addition: pc+4 wraps modulo 2^XLEN, with no carry-out.
- BTB update on a rising edge with upd_valid=1, independent of Enable and PCWrite. Let u_idx and u_tag be taken from upd_pc.
  - Entry valid and tag match:
    - ctr saturating: +1 if upd_taken (max 2'b11), -1 otherwise (min 2'b00).
    - If upd_taken, tgt <= upd_target.
  - Miss and upd_taken=1: allocate, replacing any valid entry. valid=1, tag=u_tag, tgt=upd_target, ctr=2'b10.
  - Miss and upd_taken=0: no change.
- Same-cycle lookup and update on the same index: the lookup uses pre-update contents. The new contents are visible from the next cycle.
- Latency: a BTB entry trained at edge N can steer the fetch at edge N+1.
- BTB storage is flops with no read latency.
- Reset deasserted mid-operation: the first edge after deassertion performs a normal step from RESET_VECTOR.

Test Plan:
- Reset, then PCWrite=Enable=1 with no inputs for 4 cycles -> pc = 0, 4, 8, 12, 16; pred_taken=0; mispredict_cnt=0.
- Train: upd_valid with upd_pc=0x10, upd_target=0x40, upd_taken=1. Then let pc reach 0x10 -> pred_taken=1, pred_target=0x40, next pc=0x40.
- Hysteresis: starting from ctr=2'b10 at 0x10, apply one not-taken update -> ctr=01, pred_taken=0 at 0x10. Then two taken updates -> ctr=11, and one further not-taken update leaves pred_taken=1.
- Aliasing (BTB_ENTRIES=16): entry trained at 0x10; fetch 0x50 (same idx, different tag) -> pred_taken=0, next pc=0x54. A taken update at 0x50 replaces the entry, and 0x10 then misses.
- Redirect vs stall: PCWrite=0 with redirect_valid=1 and redirect_pc=0x203 -> pc=0x200, mispredict_cnt+1. With Enable=0 the same stimulus leaves pc and the counter unchanged.
- Saturation/wrap:
  - CNT_WIDTH=2 with 5 redirects -> mispredict_cnt=3.
  - Redirect to 0xFFFFFFFC, then one step -> pc=0x0.
  - Reset_n pulsed low mid-stream -> pc=RESET_VECTOR immediately, BTB cleared.
